// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD command path: FSM state codes, response
// type codes, fixed frame bits and the CRC7 single-bit update.
package sd_cmd_pkg;

  // One-hot state codes of the command scheduler
  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_CALC  = 6'b000010,
    S_ISSUE = 6'b000100,
    S_ACK   = 6'b001000,
    S_ABORT = 6'b010000,
    S_DONE  = 6'b100000
  } state_t;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_R48  = 2'b01;
  localparam logic [1:0] RESP_R136 = 2'b10;

  localparam logic START_BIT = 1'b0;
  localparam logic TX_BIT    = 1'b1;
  localparam logic END_BIT   = 1'b1;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  // One step of the MSB-first CRC7 shift register (x^7 + x^3 + 1)
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/crc7_serial.sv
// Serial CRC7 generator, one message bit per enabled cycle, MSB first.
module crc7_serial
  import sd_cmd_pkg::*;
(
  input  logic       sd_clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  // CRC register: cleared by clr, advanced by one bit when en is high
  always_ff @(posedge sd_clock or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (reset)    crc <= 7'h00;
    else if (clr) crc <= 7'h00;
    else if (en)  crc <= crc7_step(crc, bit_in);
  end

endmodule

// File: rtl/arbitro_comandos_sd.sv
// Command scheduler for the SD CMD line: arbitrates the software and
// data-layer requesters, builds the 48-bit frame with CRC7 and runs the
// strobe/ack handshake with the physical layer, aborting it on timeout.
module arbitro_comandos_sd
  import sd_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ABORT_CYCLES   = 2
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         sw_req,
  input  logic [5:0]   sw_cmd_index,
  input  logic [31:0]  sw_argument,
  input  logic [1:0]   sw_resp_type,
  output logic         sw_grant,
  output logic         sw_done,
  input  logic         dl_req,
  input  logic [5:0]   dl_cmd_index,
  input  logic [31:0]  dl_argument,
  input  logic [1:0]   dl_resp_type,
  output logic         dl_grant,
  output logic         dl_done,
  output logic         busy,
  output logic [127:0] resp_data,
  output logic         resp_timeout,
  output logic [47:0]  cmd_frame,
  output logic         no_response,
  output logic         strobe_out,
  output logic         ack_out,
  output logic         idle_out,
  input  logic         strobe_in,
  input  logic         ack_in,
  input  logic [127:0] response,
  input  logic         command_timeout
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int AB_W = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;

  state_t      state, state_nxt;
  logic [5:0]  lat_index;
  logic [31:0] lat_arg;
  logic [1:0]  lat_type;
  logic        lat_dl;
  logic [5:0]  bit_cnt;
  logic [WD_W-1:0] wd;
  logic [AB_W-1:0] ab_cnt;
  logic [6:0]  crc;
  logic [1:0]  req_type, req_type_norm;

  // The grant is decoded from the live request so the latency from grant to
  // strobe_out is the IDLE cycle plus the 40 CALC cycles; it is masked
  // while reset is high so that reset forces every output low.
  wire grant_dl  = (state == S_IDLE) && dl_req && !reset;
  wire grant_sw  = (state == S_IDLE) && sw_req && !dl_req && !reset;
  wire grant_any = grant_dl || grant_sw;

  wire [39:0] header    = {START_BIT, TX_BIT, lat_index, lat_arg};
  wire [5:0]  calc_idx  = 6'd39 - bit_cnt;
  wire        calc_bit  = header[calc_idx];
  wire        calc_last = (bit_cnt == 6'd39);
  wire        wd_expired = (wd == WD_W'(TIMEOUT_CYCLES - 1));
  wire        ab_last    = (ab_cnt == AB_W'(ABORT_CYCLES - 1));

  crc7_serial u_crc (
    .sd_clock (sd_clock),
    .reset    (reset),
    .clr      (grant_any),
    .en       (state == S_CALC),
    .bit_in   (calc_bit),
    .crc      (crc)
  );

  // Response type of the winning requester, 11 folded onto the 48-bit code
  always_comb begin
    req_type = grant_dl ? dl_resp_type : sw_resp_type;
    unique case (req_type)
      RESP_NONE: req_type_norm = RESP_NONE;
      RESP_R136: req_type_norm = RESP_R136;
      default:   req_type_norm = RESP_R48;
    endcase
  end

  // State register
  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (grant_any) state_nxt = S_CALC;
      S_CALC:  if (calc_last) state_nxt = S_ISSUE;
      S_ISSUE: if (strobe_in) state_nxt = S_ACK;
               else if (command_timeout || wd_expired) state_nxt = S_ABORT;
      S_ACK:   if (ack_in) state_nxt = S_DONE;
               else if (wd_expired) state_nxt = S_ABORT;
      S_ABORT: if (ab_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs plus the grant decode
  always_comb begin
    sw_grant    = grant_sw;
    dl_grant    = grant_dl;
    strobe_out  = (state == S_ISSUE);
    ack_out     = (state == S_ACK);
    idle_out    = (state == S_ABORT);
    sw_done     = (state == S_DONE) && !lat_dl;
    dl_done     = (state == S_DONE) && lat_dl;
    busy        = (state != S_IDLE) || grant_any;
    no_response = (state != S_IDLE) && (lat_type == RESP_NONE);
  end

  // Datapath: command latch, CRC bit counter, frame, watchdog, abort timer, response
  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      lat_index    <= '0;
      lat_arg      <= '0;
      lat_type     <= RESP_NONE;
      lat_dl       <= 1'b0;
      bit_cnt      <= '0;
      wd           <= '0;
      ab_cnt       <= '0;
      cmd_frame    <= '0;
      resp_data    <= '0;
      resp_timeout <= 1'b0;
    end else begin
      ab_cnt <= '0;
      if (grant_any) begin
        lat_index    <= grant_dl ? dl_cmd_index : sw_cmd_index;
        lat_arg      <= grant_dl ? dl_argument  : sw_argument;
        lat_type     <= req_type_norm;
        lat_dl       <= grant_dl;
        bit_cnt      <= '0;
        resp_data    <= '0;
        resp_timeout <= 1'b0;
      end
      if (state == S_CALC) begin
        bit_cnt <= bit_cnt + 6'd1;
        wd      <= '0;
        if (calc_last) cmd_frame <= {header, crc7_step(crc, calc_bit), END_BIT};
      end
      if ((state == S_ISSUE || state == S_ACK) && !wd_expired) wd <= wd + WD_W'(1);
      if (state == S_ISSUE && strobe_in) resp_data <= response;
      if (state == S_ABORT) begin
        ab_cnt       <= ab_cnt + AB_W'(1);
        resp_data    <= '0;
        resp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_comandos_sd.sv
// Self-checking bench for arbitro_comandos_sd: directed scenarios plus a
// randomized loop, checked against a CRC7 long-division model and the
// handshake timing rules.
module tb_arbitro_comandos_sd;

  localparam int TO = 64;

  logic         sd_clock = 1'b0;
  logic         reset;
  logic         sw_req, dl_req;
  logic [5:0]   sw_cmd_index, dl_cmd_index;
  logic [31:0]  sw_argument, dl_argument;
  logic [1:0]   sw_resp_type, dl_resp_type;
  logic         sw_grant, sw_done, dl_grant, dl_done, busy;
  logic [127:0] resp_data, response;
  logic         resp_timeout, no_response, strobe_out, ack_out, idle_out;
  logic [47:0]  cmd_frame;
  logic         strobe_in, ack_in, command_timeout;

  int total = 0;
  int bad   = 0;

  arbitro_comandos_sd #(.TIMEOUT_CYCLES(TO), .ABORT_CYCLES(2)) dut (
    .sd_clock(sd_clock), .reset(reset),
    .sw_req(sw_req), .sw_cmd_index(sw_cmd_index), .sw_argument(sw_argument),
    .sw_resp_type(sw_resp_type), .sw_grant(sw_grant), .sw_done(sw_done),
    .dl_req(dl_req), .dl_cmd_index(dl_cmd_index), .dl_argument(dl_argument),
    .dl_resp_type(dl_resp_type), .dl_grant(dl_grant), .dl_done(dl_done),
    .busy(busy), .resp_data(resp_data), .resp_timeout(resp_timeout),
    .cmd_frame(cmd_frame), .no_response(no_response), .strobe_out(strobe_out),
    .ack_out(ack_out), .idle_out(idle_out), .strobe_in(strobe_in),
    .ack_in(ack_in), .response(response), .command_timeout(command_timeout)
  );

  always #5 sd_clock = ~sd_clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC7 as the remainder of polynomial division of msg*x^7 by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i-:8] = r[i-:8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] frame_ref(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
  endfunction

  task automatic tick();
    @(negedge sd_clock);
    #1;
  endtask

  task automatic put_req(input bit is_dl, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] rt);
    if (is_dl) begin
      dl_cmd_index = idx; dl_argument = arg; dl_resp_type = rt; dl_req = 1'b1;
    end else begin
      sw_cmd_index = idx; sw_argument = arg; sw_resp_type = rt; sw_req = 1'b1;
    end
  endtask

  // mode: 0 normal, 1 command_timeout pulse, 2 silent phy, 3 strobe_in+timeout together
  task automatic serve(input bit is_dl, input logic [5:0] idx, input logic [31:0] arg,
                       input logic [1:0] rt, input int mode, input int dly, input int ack_dly,
                       input bit idle_after);
    logic got;
    int n;
    logic [127:0] rsp, exp_rsp;
    logic exp_to;
    got = 1'b0;
    #1;
    for (int i = 0; i < 300 && !got; i++) begin
      if (i > 0) tick();
      got = is_dl ? dl_grant : sw_grant;
    end
    check("grant", 128'(got), 128'(1));
    if (!got) return;
    check("grant_other", 128'(is_dl ? sw_grant : dl_grant), 128'(0));
    check("busy_at_grant", 128'(busy), 128'(1));
    n = 0;
    while (!strobe_out && n < 100) begin tick(); n++; end
    check("grant_to_strobe", 128'(n), 128'(41));
    check("cmd_frame", 128'(cmd_frame), 128'(frame_ref(idx, arg)));
    check("no_response", 128'(no_response), 128'(rt == 2'b00));
    exp_rsp = '0;
    exp_to  = 1'b0;
    case (mode)
      0, 3: begin
        repeat (dly) tick();
        rsp = {$urandom(), $urandom(), $urandom(), $urandom()};
        response  = rsp;
        strobe_in = 1'b1;
        if (mode == 3) command_timeout = 1'b1;
        tick();
        strobe_in = 1'b0; command_timeout = 1'b0;
        response  = {$urandom(), $urandom(), $urandom(), $urandom()};
        check("ack_out", 128'(ack_out), 128'(1));
        check("strobe_drop", 128'(strobe_out), 128'(0));
        repeat (ack_dly) tick();
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        check("no_abort", 128'(idle_out), 128'(0));
        exp_rsp = rsp;
      end
      1: begin
        repeat (dly) tick();
        command_timeout = 1'b1;
        tick();
        command_timeout = 1'b0;
        n = 0;
        while (idle_out && n < 10) begin n++; tick(); end
        check("idle_cycles", 128'(n), 128'(2));
        exp_to = 1'b1;
      end
      default: begin
        n = 0;
        while (strobe_out && n < 200) begin n++; tick(); end
        check("watchdog_cycles", 128'(n), 128'(TO));
        check("idle_at_expiry", 128'(idle_out), 128'(1));
        n = 0;
        while (idle_out && n < 10) begin n++; tick(); end
        check("idle_cycles", 128'(n), 128'(2));
        exp_to = 1'b1;
      end
    endcase
    check("done", 128'(is_dl ? dl_done : sw_done), 128'(1));
    check("done_other", 128'(is_dl ? sw_done : dl_done), 128'(0));
    check("resp_data", resp_data, exp_rsp);
    check("resp_timeout", 128'(resp_timeout), 128'(exp_to));
    if (is_dl) dl_req = 1'b0; else sw_req = 1'b0;
    tick();
    check("done_width", 128'(is_dl ? dl_done : sw_done), 128'(0));
    if (idle_after) check("busy_drop", 128'(busy), 128'(0));
  endtask

  initial begin
    logic [31:0] a;
    logic ok;
    reset = 1'b1;
    sw_req = 0; dl_req = 0; sw_cmd_index = 0; dl_cmd_index = 0;
    sw_argument = 0; dl_argument = 0; sw_resp_type = 0; dl_resp_type = 0;
    strobe_in = 0; ack_in = 0; command_timeout = 0; response = '0;
    tick();
    check("reset_ctl", 128'({sw_grant, dl_grant, sw_done, dl_done, busy, resp_timeout,
                             no_response, strobe_out, ack_out, idle_out}), 128'(0));
    check("reset_resp", resp_data, 128'(0));
    check("reset_frame", 128'(cmd_frame), 128'(0));
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // CMD0, no response, phy answers 60 cycles into ISSUE
    put_req(0, 6'd0, 32'h0, 2'b00);
    serve(0, 6'd0, 32'h0, 2'b00, 0, 60, 0, 1);
    check("frame_cmd0", 128'(cmd_frame), 128'(48'h400000000095));

    // CMD8, 48-bit response
    put_req(0, 6'd8, 32'h1AA, 2'b01);
    serve(0, 6'd8, 32'h1AA, 2'b01, 0, 7, 3, 1);
    check("frame_cmd8", 128'(cmd_frame), 128'(48'h48000001AA87));

    // Simultaneous dl CMD12 and sw CMD13: dl first, sw right after dl_done
    a = {$urandom_range(0, 65535), 16'h0};
    put_req(1, 6'd12, 32'h0, 2'b01);
    put_req(0, 6'd13, a, 2'b11);
    serve(1, 6'd12, 32'h0, 2'b01, 0, 4, 2, 0);
    check("frame_cmd12", 128'(cmd_frame), 128'(48'h4C0000000061));
    serve(0, 6'd13, a, 2'b11, 0, 3, 1, 1);

    // Physical-layer timeout pulse during ISSUE
    put_req(0, 6'd17, 32'h1234, 2'b01);
    serve(0, 6'd17, 32'h1234, 2'b01, 1, 5, 0, 1);

    // Silent phy: watchdog abort; then strobe_in and timeout in one cycle
    put_req(1, 6'd18, 32'hCAFE0000, 2'b10);
    serve(1, 6'd18, 32'hCAFE0000, 2'b10, 2, 0, 0, 1);
    put_req(0, 6'd2, 32'h0, 2'b10);
    serve(0, 6'd2, 32'h0, 2'b10, 3, 10, 0, 1);

    // Randomized commands
    for (int k = 0; k < 8; k++) begin
      bit side;
      logic [5:0] idx;
      logic [1:0] rt;
      int md;
      side = 1'($urandom_range(0, 1));
      idx  = 6'($urandom_range(0, 63));
      rt   = 2'($urandom_range(0, 3));
      a    = $urandom();
      case ($urandom_range(0, 3))
        0, 1:    md = 0;
        2:       md = 1;
        default: md = 3;
      endcase
      put_req(side, idx, a, rt);
      serve(side, idx, a, rt, md, $urandom_range(0, 30), $urandom_range(0, 20), 1);
    end

    // Reset in the middle of CALC abandons the command without a done pulse
    put_req(0, 6'd0, 32'h0, 2'b00);
    #1;
    check("grant_before_reset", 128'(sw_grant), 128'(1));
    repeat (10) tick();
    reset = 1'b1;
    #1;
    check("midreset_ctl", 128'({sw_grant, dl_grant, sw_done, dl_done, busy, resp_timeout,
                                no_response, strobe_out, ack_out, idle_out}), 128'(0));
    check("midreset_frame", 128'(cmd_frame), 128'(0));
    ok = 1'b1;
    repeat (3) begin
      tick();
      if (sw_done || dl_done || busy) ok = 1'b0;
    end
    check("no_done_in_reset", 128'(ok), 128'(1));
    reset = 1'b0;
    serve(0, 6'd0, 32'h0, 2'b00, 0, 60, 0, 1);
    check("frame_cmd0_after_reset", 128'(cmd_frame), 128'(48'h400000000095));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
